bus_wbuf: RTL and testbench
===========================

// Module: bus_wbuf
//
// PURPOSE
// - Parametrised write-channel buffer between a bus master port and a bus slave port (wvalid/wready/waddr/wdata).
// - Decouples producer and consumer: absorbs up to DEPTH writes while downstream stalls; in-order, lossless.
// - Sits on the write path between a master and its slave, e.g. register-bank and DMA write channels.
//
// PARAMETERS
// - BAW    32  address width (bits)
// - BDW    32  data width (bits)
// - DEPTH  4   entries; power of two, >= 2
//
// PORTS
// - clk       in   1          clock, all logic on posedge
// - rst       in   1          asynchronous reset, active high
// - flush     in   1          synchronous clear of all entries
// - s_wvalid  in   1          upstream write valid
// - s_wready  out  1          upstream write ready
// - s_waddr   in   BAW        upstream address
// - s_wdata   in   BDW        upstream data
// - m_wvalid  out  1          downstream write valid
// - m_wready  in   1          downstream write ready
// - m_waddr   out  BAW        downstream address (head entry)
// - m_wdata   out  BDW        downstream data (head entry)
// - level     out  $clog2(DEPTH)+1  current entry count, 0..DEPTH
//
// BEHAVIOUR
// - Reset (async assert, sync release): level=0, m_wvalid=0, m_waddr=0, m_wdata=0, s_wready=0 while rst high.
// - Push = s_wvalid & s_wready at posedge. Pop = m_wvalid & m_wready at posedge.
// - s_wready = (level < DEPTH) & ~rst; no combinational path from m_wready to s_wready.
// - m_wvalid = (level != 0); m_waddr/m_wdata always show the oldest entry.
// - Latency: push at edge N -> m_wvalid high after edge N (visible cycle N+1); 1-cycle min.
// - Stability: while m_wvalid & ~m_wready, m_waddr/m_wdata/m_wvalid hold unchanged.
// - Push+pop same edge: level unchanged, order preserved; allowed at any level 1..DEPTH-1.
// - Full (level=DEPTH): s_wready=0, no push; a pop frees a slot, s_wready=1 next cycle.
// - Empty (level=0): pop impossible; push with level=0 is stored, not bypassed (unless macro).
// - Pointers: rd/wr pointers of $clog2(DEPTH) bits wrap modulo DEPTH; level tracked separately.
// - flush: at edge, level=0, pointers=0, m_wvalid=0 next cycle; flush wins over simultaneous
//   push and pop (push discarded, pop ignored). s_wready stays 1 during flush.
// - Reset mid-transfer: all entries lost, outputs go to reset values immediately.
// - Storage array needs no reset; only pointers, level and output regs are reset.
//
// CONFIGURATION
// - WBUF_BYPASS_EN defined: when level=0 and m_wready=1, s_wvalid passes through to
//   m_wvalid combinationally in the same cycle with s_waddr/s_wdata on m_waddr/m_wdata;
//   the transfer is not stored (level stays 0). s_wready is 1 in that case.
// - WBUF_BYPASS_EN undefined: no combinational s_->m_ path; min latency 1 cycle as above.
//
// TESTING
// - Reset: rst=1 mid-stream with level=3 -> level=0, m_wvalid=0, s_wready=0 immediately; s_wready=1 after release.
// - Single write: s_ push addr=0x10 data=0xCAFE, m_wready=1 -> m_wvalid 1 cycle later with
//   0x10/0xCAFE; one pop; level back to 0 (bypass on: same-cycle on m_, level stays 0).
// - Fill/stall: m_wready=0, push 5 writes with DEPTH=4 -> first 4 accepted, s_wready=0,
//   level=4; release m_wready -> pops in order 0..3, 5th write accepted after first pop.
// - Throughput: continuous s_wvalid and m_wready=1 for 64 writes -> one transfer per cycle,
//   data order/values match, level never exceeds 1 (bypass on: 0).
// - Flush race: level=2, assert flush with s_wvalid=1 and m_wready=1 -> level=0, m_wvalid=0 next cycle, pushed entry absent.
// - Random stall: random s_wvalid/m_wready 10k cycles, DEPTH=2 and 8 -> scoreboard match, no loss/dup, m_* stable while stalled.

Source files
------------

// File: rtl/bus_wbuf.sv
// In-order write-channel buffer between a bus master and a bus slave.
// Optional WBUF_BYPASS_EN: same-cycle pass-through when empty and ready.
module bus_wbuf #(
  parameter int BAW   = 32,
  parameter int BDW   = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     s_wvalid,
  output logic                     s_wready,
  input  logic [BAW-1:0]           s_waddr,
  input  logic [BDW-1:0]           s_wdata,
  output logic                     m_wvalid,
  input  logic                     m_wready,
  output logic [BAW-1:0]           m_waddr,
  output logic [BDW-1:0]           m_wdata,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  logic [BAW-1:0] addr_q [DEPTH];
  logic [BDW-1:0] data_q [DEPTH];

  logic [PW-1:0] rd_q, rd_d;
  logic [PW-1:0] wr_q, wr_d;
  logic [LW-1:0] lvl_q, lvl_d;

  logic byp;
  logic push;
  logic pop;
  logic nempty;

  always_comb begin
    byp = 1'b0;
`ifdef WBUF_BYPASS_EN
    byp = ~rst & (lvl_q == '0) & m_wready;
`endif
    nempty   = (lvl_q != '0);
    s_wready = ~rst & ((lvl_q < LW'(DEPTH)) | flush);
    m_wvalid = nempty | (byp & s_wvalid);
    m_waddr  = '0;
    m_wdata  = '0;
    if (byp) begin
      m_waddr = s_waddr;
      m_wdata = s_wdata;
    end else if (nempty) begin
      m_waddr = addr_q[rd_q];
      m_wdata = data_q[rd_q];
    end
    // bypassed beats are consumed downstream and never stored
    push = s_wvalid & s_wready & ~byp & ~flush;
    pop  = nempty & m_wready & ~flush;
  end

  always_comb begin
    rd_d  = rd_q;
    wr_d  = wr_q;
    lvl_d = lvl_q;
    if (flush) begin
      rd_d  = '0;
      wr_d  = '0;
      lvl_d = '0;
    end else begin
      if (push) wr_d = wr_q + 1'b1;
      if (pop)  rd_d = rd_q + 1'b1;
      case ({push, pop})
        2'b10:   lvl_d = lvl_q + 1'b1;
        2'b01:   lvl_d = lvl_q - 1'b1;
        default: lvl_d = lvl_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q  <= '0;
      wr_q  <= '0;
      lvl_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      lvl_q <= lvl_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[wr_q] <= s_waddr;
      data_q[wr_q] <= s_wdata;
    end
  end

  assign level = lvl_q;
endmodule

// File: tb/tb_bus_wbuf.sv
// Scoreboard bench for bus_wbuf: directed phases plus random traffic.
// The reference model is a plain queue of expected {addr,data} beats.
module tb_bus_wbuf;
  localparam int DEPTH = 4;
  localparam int LW = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  logic s_wvalid = 1'b0;
  logic s_wready;
  logic [31:0] s_waddr = '0;
  logic [31:0] s_wdata = '0;
  logic m_wvalid;
  logic m_wready = 1'b0;
  logic [31:0] m_waddr;
  logic [31:0] m_wdata;
  logic [LW-1:0] level;

  bus_wbuf #(.BAW(32), .BDW(32), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_waddr(s_waddr), .s_wdata(s_wdata),
    .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_waddr(m_waddr), .m_wdata(m_wdata),
    .level(level)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int pops = 0;
  int max_lvl = 0;
  longint cyc = 0;

  logic [63:0] exp_q[$];
  logic prev_stall = 1'b0;
  logic [31:0] prev_a, prev_d;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc++;

  // monitor: compare DUT against the queue model, then advance the model
  always @(negedge clk) begin
    logic ewr, byp, evld;
    if (rst) begin
      exp_q.delete();
      chk("rst_s_wready", s_wready, 0);
      chk("rst_level", level, 0);
      chk("rst_m_wvalid", m_wvalid, 0);
      prev_stall = 1'b0;
    end else begin
      ewr = (exp_q.size() < DEPTH) || flush;
      byp = 1'b0;
`ifdef WBUF_BYPASS_EN
      byp = (exp_q.size() == 0) && m_wready && s_wvalid;
`endif
      evld = (exp_q.size() != 0) || byp;
      chk("s_wready", s_wready, ewr);
      chk("level", level, exp_q.size());
      chk("m_wvalid", m_wvalid, evld);
      if (byp) begin
        chk("byp_addr", m_waddr, s_waddr);
        chk("byp_data", m_wdata, s_wdata);
      end else if (exp_q.size() != 0) begin
        chk("head_addr", m_waddr, exp_q[0][63:32]);
        chk("head_data", m_wdata, exp_q[0][31:0]);
      end
      if (prev_stall) begin
        chk("stall_addr", m_waddr, prev_a);
        chk("stall_data", m_wdata, prev_d);
        chk("stall_valid", m_wvalid, 1);
      end
      if (int'(level) > max_lvl) max_lvl = int'(level);
      prev_stall = !flush && evld && !m_wready;
      prev_a = m_waddr;
      prev_d = m_wdata;
      if (flush) begin
        exp_q.delete();
      end else begin
        if (evld && m_wready) begin
          pops++;
          if (!byp) void'(exp_q.pop_front());
        end
        if (s_wvalid && ewr && !byp) exp_q.push_back({s_waddr, s_wdata});
      end
    end
  end

  task automatic send(input logic [31:0] a, input logic [31:0] d);
    int n;
    n = 0;
    s_wvalid = 1'b1;
    s_waddr = a;
    s_wdata = d;
    @(negedge clk);
    while (!s_wready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: s_wready stuck 0 expected 1");
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    s_wvalid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    longint t0;
    int p0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    idle(1);

    // single write
    m_wready = 1'b1;
    send(32'h10, 32'hCAFE);
    idle(3);
    chk("single_level", level, 0);

    // fill and stall
    m_wready = 1'b0;
    for (int i = 0; i < 4; i++) send(32'h100 + i, 32'hA0 + i);
    s_wvalid = 1'b1;
    s_waddr = 32'h104;
    s_wdata = 32'hA4;
    @(negedge clk);
    chk("full_level", level, DEPTH);
    chk("full_s_wready", s_wready, 0);
    @(posedge clk);
    #1 m_wready = 1'b1;
    send(32'h104, 32'hA4);
    idle(8);

    // throughput
    max_lvl = 0;
    p0 = pops;
    t0 = cyc;
    for (int i = 0; i < 64; i++) send(32'h2000 + i, $urandom);
    idle(4);
    chk("tput_pops", pops - p0, 64);
    chk("tput_cycles_ok", (cyc - t0) <= 64 + 6, 1);
`ifdef WBUF_BYPASS_EN
    chk("tput_max_level", max_lvl, 0);
`else
    chk("tput_max_level", max_lvl, 1);
`endif

    // flush race at level 2
    m_wready = 1'b0;
    send(32'h300, 32'h1);
    send(32'h301, 32'h2);
    s_wvalid = 1'b1;
    s_waddr = 32'h302;
    m_wready = 1'b1;
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    s_wvalid = 1'b0;
    @(negedge clk);
    chk("flush_level", level, 0);
    chk("flush_m_wvalid", m_wvalid, 0);
    idle(2);

    // random traffic
    for (int i = 0; i < 10000; i++) begin
      s_wvalid = ($urandom % 2) == 0;
      s_waddr = $urandom;
      s_wdata = $urandom;
      m_wready = (i / 1000) % 2 == 0 ? ($urandom % 4) != 0 : ($urandom % 3) == 0;
      flush = ($urandom % 500) == 0;
      @(posedge clk);
      #1;
    end
    flush = 1'b0;
    s_wvalid = 1'b0;
    m_wready = 1'b1;
    idle(DEPTH + 3);
    chk("drain_level", level, 0);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_queue: %0d left expected 0", exp_q.size());
    end

    // reset mid-stream at level 3
    m_wready = 1'b0;
    for (int i = 0; i < 3; i++) send(32'h400 + i, 32'h40 + i);
    s_wvalid = 1'b0;
    @(negedge clk);
    chk("pre_rst_level", level, 3);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("rst_now_level", level, 0);
    chk("rst_now_m_wvalid", m_wvalid, 0);
    chk("rst_now_s_wready", s_wready, 0);
    chk("rst_now_m_waddr", m_waddr, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_s_wready", s_wready, 1);
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
